mem_access_stage: RTL

Consumer end of the EX/MEM pipeline interface: takes the registered EX/MEM control and data fields, performs the data-memory load or store over a req/ack bus with arbitrary wait states, and selects the write-back value. It stalls the upstream pipeline while an access is outstanding. It drives the MEM/WB register fields that feed the register file and the forwarding logic.

---
 rtl/cpu_mem_pkg.sv | 40 ++++
 rtl/mem_wb_reg.sv | 34 +++
 rtl/mem_access_stage.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared types for the memory-access stage: FSM states, write-back select codes, MEM/WB payload.
package cpu_mem_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;
    localparam int unsigned SEL_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } mem_state_e;

    localparam logic [SEL_W-1:0] WB_ALU = 2'b00;
    localparam logic [SEL_W-1:0] WB_MEM = 2'b01;
    localparam logic [SEL_W-1:0] WB_PC4 = 2'b10;

    typedef struct packed {
        logic             regwrite;
        logic [REG_W-1:0] rd;
        logic [XLEN-1:0]  data;
    } mem_wb_t;

    // Write-back source select; the unused code 11 falls back to the ALU result.
    function automatic logic [XLEN-1:0] wb_mux(
        input logic [SEL_W-1:0] sel,
        input logic [XLEN-1:0]  alu,
        input logic [XLEN-1:0]  mem,
        input logic [XLEN-1:0]  pc4
    );
        logic [XLEN-1:0] res;
        case (sel)
            WB_MEM:  res = mem;
            WB_PC4:  res = pc4;
            default: res = alu;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register; a bubble loads an all-zero (non-writing) entry.
module mem_wb_reg
    import cpu_mem_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    bubble,
    input  mem_wb_t wb_in,
    output mem_wb_t wb_out
);

    mem_wb_t wb_d;
    mem_wb_t wb_q;

    // Next entry: incoming fields or a bubble
    always_comb begin
        wb_d = wb_in;
        if (bubble) begin
            wb_d = '0;
        end
    end

    // Register loads every cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_q <= '0;
        end else begin
            wb_q <= wb_d;
        end
    end

    assign wb_out = wb_q;

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: req/ack data-memory access, stall generation, MEM/WB write-back.
// Optional macro MEM_ALIGN_CHECK_EN: misaligned accesses are dropped and flagged on align_err;
// without it the low two address bits are forced to zero on the bus.
module mem_access_stage
    import cpu_mem_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MemRead_in,
    input  logic                  MemWrite_in,
    input  logic                  RegWrite_in,
    input  logic [SEL_W-1:0]      MemtoReg_in,
    input  logic [REG_W-1:0]      rd_in,
    input  logic [XLEN-1:0]       ALUout_in,
    input  logic [XLEN-1:0]       regB_in,
    input  logic [XLEN-1:0]       PCadd4_in,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [XLEN-1:0]       mem_addr,
    output logic [XLEN-1:0]       mem_wdata,
    input  logic                  mem_ack,
    input  logic [XLEN-1:0]       mem_rdata,
    output logic                  stall,
`ifdef MEM_ALIGN_CHECK_EN
    output logic                  align_err,
`endif
    output logic                  RegWrite_out,
    output logic [REG_W-1:0]      rd_out,
    output logic [XLEN-1:0]       wb_data_out
);

    mem_state_e        state_d, state_q;
    logic              mem_req_d, mem_req_q;
    logic              mem_we_d, mem_we_q;
    logic [XLEN-1:0]   alu_d, alu_q;
    logic [XLEN-1:0]   wdata_d, wdata_q;
    logic [XLEN-1:0]   pc4_d, pc4_q;
    logic [XLEN-1:0]   rdata_d, rdata_q;
    logic [REG_W-1:0]  rd_lat_d, rd_lat_q;
    logic              rw_lat_d, rw_lat_q;
    logic [SEL_W-1:0]  sel_lat_d, sel_lat_q;
`ifdef MEM_ALIGN_CHECK_EN
    logic              align_err_d, align_err_q;
`endif
    logic              access;
    logic              misaligned;
    logic              bubble;
    mem_wb_t           wb_next;
    mem_wb_t           wb_cur;

    assign access = MemRead_in | MemWrite_in;
`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = (ALUout_in[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // Next-state, latched access fields, stall and MEM/WB source selection
    always_comb begin
        state_d   = state_q;
        mem_req_d = mem_req_q;
        mem_we_d  = mem_we_q;
        alu_d     = alu_q;
        wdata_d   = wdata_q;
        pc4_d     = pc4_q;
        rdata_d   = rdata_q;
        rd_lat_d  = rd_lat_q;
        rw_lat_d  = rw_lat_q;
        sel_lat_d = sel_lat_q;
`ifdef MEM_ALIGN_CHECK_EN
        align_err_d = 1'b0;
`endif
        stall     = 1'b0;
        bubble    = 1'b0;
        wb_next   = '{regwrite: RegWrite_in, rd: rd_in,
                      data: wb_mux(MemtoReg_in, ALUout_in, rdata_q, PCadd4_in)};

        case (state_q)
            IDLE: begin
                if (access) begin
                    bubble = 1'b1;
                    if (misaligned) begin
`ifdef MEM_ALIGN_CHECK_EN
                        align_err_d = 1'b1;
`endif
                    end else begin
                        stall     = 1'b1;
                        mem_req_d = 1'b1;
                        mem_we_d  = MemWrite_in;
                        alu_d     = ALUout_in;
                        wdata_d   = regB_in;
                        pc4_d     = PCadd4_in;
                        rd_lat_d  = rd_in;
                        rw_lat_d  = RegWrite_in;
                        sel_lat_d = MemtoReg_in;
                        state_d   = REQ;
                    end
                end
            end
            REQ: begin
                stall  = 1'b1;
                bubble = 1'b1;
                if (mem_ack) begin
                    rdata_d   = mem_rdata;
                    mem_req_d = 1'b0;
                    state_d   = DONE;
                end
            end
            DONE: begin
                wb_next = '{regwrite: rw_lat_q, rd: rd_lat_q,
                            data: wb_mux(sel_lat_q, alu_q, rdata_q, pc4_q)};
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Stage state and bus registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            alu_q     <= '0;
            wdata_q   <= '0;
            pc4_q     <= '0;
            rdata_q   <= '0;
            rd_lat_q  <= '0;
            rw_lat_q  <= 1'b0;
            sel_lat_q <= '0;
`ifdef MEM_ALIGN_CHECK_EN
            align_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            mem_req_q <= mem_req_d;
            mem_we_q  <= mem_we_d;
            alu_q     <= alu_d;
            wdata_q   <= wdata_d;
            pc4_q     <= pc4_d;
            rdata_q   <= rdata_d;
            rd_lat_q  <= rd_lat_d;
            rw_lat_q  <= rw_lat_d;
            sel_lat_q <= sel_lat_d;
`ifdef MEM_ALIGN_CHECK_EN
            align_err_q <= align_err_d;
`endif
        end
    end

    mem_wb_reg u_mem_wb_reg (
        .clk    (clk),
        .rst_n  (reset),
        .bubble (bubble),
        .wb_in  (wb_next),
        .wb_out (wb_cur)
    );

    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = {alu_q[XLEN-1:2], 2'b00};
    assign mem_wdata    = wdata_q;
    assign RegWrite_out = wb_cur.regwrite;
    assign rd_out       = wb_cur.rd;
    assign wb_data_out  = wb_cur.data;
`ifdef MEM_ALIGN_CHECK_EN
    assign align_err    = align_err_q;
`endif

endmodule
